// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register-access slice: response status codes and
// the host-side access state machine encoding.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY   = 2'b00,
    RGGEN_SLVERR = 2'b10
  } rggen_status_e;

  typedef enum logic [1:0] {
    RGGEN_IDLE,
    RGGEN_ACCESS,
    RGGEN_RESPONSE
  } rggen_access_state_e;

endpackage

// File: rtl/rggen_address_decoder.sv
// Word-granular address match for one register, plus the read/write
// permission check that decides whether the access reaches its bit fields.
module rggen_address_decoder
  import rggen_rtl_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH    = 8,
  parameter int                       BUS_WIDTH        = 32,
  parameter logic [ADDRESS_WIDTH-1:0] REGISTER_ADDRESS = '0,
  parameter bit                       WRITABLE         = 1'b1,
  parameter bit                       READABLE         = 1'b1
) (
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic                     i_write,
  output logic                     o_hit,
  output logic                     o_access
);

  localparam int                       LSB       = $clog2(BUS_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] BYTE_MASK = ADDRESS_WIDTH'((1 << LSB) - 1);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = ~BYTE_MASK;

  // Byte-lane bits are masked off rather than sliced so the match also
  // covers a byte-wide bus where there are no lane bits to drop.
  assign o_hit    = (i_address & WORD_MASK) == (REGISTER_ADDRESS & WORD_MASK);
  assign o_access = o_hit && (i_write ? WRITABLE : READABLE);

endmodule

// File: rtl/rggen_register_access_ctrl.sv
// Single-outstanding host-to-register access controller: accepts a request,
// strobes the addressed register's bit fields for one cycle, then holds a
// response until the host consumes it.
module rggen_register_access_ctrl
  import rggen_rtl_pkg::*;
#(
  parameter int                                        ADDRESS_WIDTH    = 8,
  parameter int                                        BUS_WIDTH        = 32,
  parameter int                                        REGISTERS        = 4,
  parameter logic [REGISTERS-1:0][ADDRESS_WIDTH-1:0]   REGISTER_ADDRESS = {8'h0C, 8'h08, 8'h04, 8'h00},
  parameter logic [REGISTERS-1:0]                      WRITABLE         = '1,
  parameter logic [REGISTERS-1:0]                      READABLE         = '1,
  parameter bit                                        ERROR_STATUS     = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic                           i_req_write,
  input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
  input  logic [BUS_WIDTH-1:0]           i_req_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_req_strobe,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [1:0]                     o_rsp_status,
  output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
  output logic [REGISTERS-1:0]           o_field_valid,
  output logic                           o_field_write,
  output logic [BUS_WIDTH-1:0]           o_field_write_data,
  output logic [BUS_WIDTH-1:0]           o_field_write_mask,
  input  logic [REGISTERS*BUS_WIDTH-1:0] i_field_read_data
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;

  rggen_access_state_e         r_state;
  rggen_access_state_e         w_next_state;
  logic                        r_write;
  logic [ADDRESS_WIDTH-1:0]    r_address;
  logic [BUS_WIDTH-1:0]        r_write_data;
  logic [STROBE_WIDTH-1:0]     r_strobe;
  logic [BUS_WIDTH-1:0]        r_read_data;
  rggen_status_e               r_status;
  logic [REGISTERS-1:0]        w_hit;
  logic [REGISTERS-1:0]        w_access;
  logic [BUS_WIDTH-1:0]        w_read_data;
  logic [BUS_WIDTH-1:0]        w_write_mask;
  logic                        w_accept;

  for (genvar g = 0; g < REGISTERS; g++) begin : g_decoder
    rggen_address_decoder #(
      .ADDRESS_WIDTH    (ADDRESS_WIDTH),
      .BUS_WIDTH        (BUS_WIDTH),
      .REGISTER_ADDRESS (REGISTER_ADDRESS[g]),
      .WRITABLE         (WRITABLE[g]),
      .READABLE         (READABLE[g])
    ) u_decoder (
      .i_address (r_address),
      .i_write   (r_write),
      .o_hit     (w_hit[g]),
      .o_access  (w_access[g])
    );
  end

  assign w_accept = i_req_valid && (r_state == RGGEN_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RGGEN_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      RGGEN_IDLE:     if (i_req_valid) w_next_state = RGGEN_ACCESS;
      RGGEN_ACCESS:   w_next_state = RGGEN_RESPONSE;
      RGGEN_RESPONSE: if (i_rsp_ready) w_next_state = RGGEN_IDLE;
      default:        w_next_state = RGGEN_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready   = (r_state == RGGEN_IDLE);
    o_rsp_valid   = (r_state == RGGEN_RESPONSE);
    o_field_valid = (r_state == RGGEN_ACCESS) ? w_access : '0;
  end

  // Request registers double as the field-side write outputs, so they keep
  // the last accessed values until the next request is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write      <= 1'b0;
      r_address    <= '0;
      r_write_data <= '0;
      r_strobe     <= '0;
    end else if (w_accept) begin
      r_write      <= i_req_write;
      r_address    <= i_req_address;
      r_write_data <= i_req_write_data;
      r_strobe     <= i_req_strobe;
    end
  end

  always_comb begin
    w_read_data = '0;
    for (int unsigned k = 0; k < REGISTERS; k++) begin
      if (w_access[k] && !r_write) begin
        w_read_data = w_read_data | i_field_read_data[k*BUS_WIDTH+:BUS_WIDTH];
      end
    end
  end

  always_comb begin
    w_write_mask = '0;
    for (int unsigned b = 0; b < STROBE_WIDTH; b++) begin
      if (r_strobe[b] && r_write) begin
        w_write_mask[8*b+:8] = '1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_read_data <= '0;
      r_status    <= RGGEN_OKAY;
    end else if (r_state == RGGEN_ACCESS) begin
      r_read_data <= w_read_data;
      r_status    <= ((w_hit == '0) && ERROR_STATUS) ? RGGEN_SLVERR : RGGEN_OKAY;
    end
  end

  assign o_rsp_status       = r_status;
  assign o_rsp_read_data    = r_read_data;
  assign o_field_write      = r_write;
  assign o_field_write_data = r_write_data;
  assign o_field_write_mask = w_write_mask;

endmodule

// File: tb/tb_rggen_register_access_ctrl.sv
// Bench for rggen_register_access_ctrl: a default instance and a restricted
// instance (no error status, reg1 read-only, reg3 write-only) share stimulus.
module tb_rggen_register_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [7:0]  req_address;
  logic [31:0] req_write_data;
  logic [3:0]  req_strobe;
  logic        rsp_ready;
  logic [127:0] field_read_data;
  logic [31:0] fields [4];

  logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [1:0]  a_status, b_status;
  logic [31:0] a_rdata, b_rdata, a_wdata, b_wdata, a_mask, b_mask;
  logic [3:0]  a_fv, b_fv;
  logic        a_fw, b_fw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb field_read_data = {fields[3], fields[2], fields[1], fields[0]};

  rggen_register_access_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(a_req_ready),
    .i_req_write(req_write), .i_req_address(req_address), .i_req_write_data(req_write_data),
    .i_req_strobe(req_strobe), .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_status(a_status), .o_rsp_read_data(a_rdata), .o_field_valid(a_fv),
    .o_field_write(a_fw), .o_field_write_data(a_wdata), .o_field_write_mask(a_mask),
    .i_field_read_data(field_read_data)
  );

  rggen_register_access_ctrl #(
    .ERROR_STATUS (1'b0),
    .WRITABLE     (4'b1101),
    .READABLE     (4'b0111)
  ) dut_alt (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(b_req_ready),
    .i_req_write(req_write), .i_req_address(req_address), .i_req_write_data(req_write_data),
    .i_req_strobe(req_strobe), .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_status(b_status), .o_rsp_read_data(b_rdata), .o_field_valid(b_fv),
    .o_field_write(b_fw), .o_field_write_data(b_wdata), .o_field_write_mask(b_mask),
    .i_field_read_data(field_read_data)
  );

  typedef struct {
    logic [3:0]  fv;
    logic [1:0]  status;
    logic [31:0] rdata;
  } expect_t;

  int reg_addr [4] = '{8'h00, 8'h04, 8'h08, 8'h0C};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: registers are 4-byte words; an access is matched by word index.
  function automatic expect_t model(input bit w, input logic [7:0] addr,
                                    input logic [3:0] wr, input logic [3:0] rd, input bit es);
    expect_t e;
    int hit = -1;
    for (int k = 0; k < 4; k++) if (int'(addr) / 4 == reg_addr[k] / 4) hit = k;
    e.fv = 4'b0;
    e.status = (hit < 0 && es) ? 2'b10 : 2'b00;
    e.rdata = 32'h0;
    if (hit >= 0 && (w ? wr[hit] : rd[hit])) begin
      e.fv[hit] = 1'b1;
      if (!w) e.rdata = fields[hit];
    end
    return e;
  endfunction

  function automatic logic [31:0] mask_of(input bit w, input logic [3:0] strb);
    logic [31:0] m = 32'h0;
    for (int b = 0; b < 4; b++) if (w && strb[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  task automatic txn(input string tag, input bit w, input logic [7:0] addr,
                     input logic [31:0] data, input logic [3:0] strb, input int hold);
    expect_t ea, eb;
    logic [31:0] m;
    ea = model(w, addr, 4'b1111, 4'b1111, 1'b1);
    eb = model(w, addr, 4'b1101, 4'b0111, 1'b0);
    m  = mask_of(w, strb);
    @(negedge clk);
    check({tag, ".idle_ready"}, {31'h0, a_req_ready}, 32'h1);
    req_valid = 1'b1; req_write = w; req_address = addr;
    req_write_data = data; req_strobe = strb;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check({tag, ".fv_a"}, {28'h0, a_fv}, {28'h0, ea.fv});
    check({tag, ".fv_b"}, {28'h0, b_fv}, {28'h0, eb.fv});
    check({tag, ".fwrite"}, {31'h0, a_fw}, {31'h0, w});
    check({tag, ".mask_a"}, a_mask, m);
    check({tag, ".mask_b"}, b_mask, m);
    check({tag, ".wdata"}, a_wdata, data);
    check({tag, ".access_rsp_valid"}, {31'h0, a_rsp_valid}, 32'h0);
    check({tag, ".access_ready"}, {31'h0, a_req_ready}, 32'h0);
    @(negedge clk);
    for (int h = 0; h <= hold; h++) begin
      check({tag, ".rsp_valid"}, {31'h0, a_rsp_valid}, 32'h1);
      check({tag, ".status_a"}, {30'h0, a_status}, {30'h0, ea.status});
      check({tag, ".status_b"}, {30'h0, b_status}, {30'h0, eb.status});
      check({tag, ".rdata_a"}, a_rdata, ea.rdata);
      check({tag, ".rdata_b"}, b_rdata, eb.rdata);
      check({tag, ".fv_resp"}, {28'h0, a_fv}, 32'h0);
      check({tag, ".resp_ready"}, {30'h0, a_req_ready, b_req_ready}, 32'h0);
      if (h < hold) begin
        // A competing request and changing field data must not disturb the response.
        req_valid = 1'b1; req_write = 1'b1; req_address = 8'($urandom_range(0, 15));
        req_write_data = ~data; req_strobe = 4'hF;
        for (int k = 0; k < 4; k++) fields[k] = $urandom;
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, ".back_idle"}, {30'h0, a_req_ready, a_rsp_valid}, 32'h2);
    check({tag, ".idle_fv"}, {28'h0, a_fv}, 32'h0);
    check({tag, ".held_fwrite"}, {31'h0, a_fw}, {31'h0, w});
    check({tag, ".held_wdata"}, a_wdata, data);
    check({tag, ".held_mask"}, a_mask, m);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_address = '0;
    req_write_data = '0; req_strobe = '0; rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) fields[k] = 32'h0;
    #1;
    check("reset.rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    check("reset.fv", {28'h0, a_fv}, 32'h0);
    check("reset.fields", {a_fw, a_wdata[30:0]} | a_mask, 32'h0);
    check("reset.rsp", {30'h0, a_status} | a_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.ready_after_release", {30'h0, a_req_ready, b_req_ready}, 32'h3);

    fields[3] = 32'hDEAD_BEEF;
    txn("w04",   1'b1, 8'h04, 32'hA5A5_A5A5, 4'hF, 0);
    txn("w08",   1'b1, 8'h08, 32'h1234_5678, 4'h3, 1);
    txn("r0C",   1'b0, 8'h0C, 32'h0,         4'h0, 0);
    txn("r20",   1'b0, 8'h20, 32'h0,         4'hF, 0);
    txn("hold5", 1'b0, 8'h0C, 32'h5555_AAAA, 4'h0, 5);

    // Reset in ACCESS after a read left non-zero response data behind.
    fields[1] = 32'hCAFE_F00D;
    txn("r04",   1'b0, 8'h04, 32'h0, 4'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_address = 8'h04;
    req_write_data = 32'h0F0F_0F0F; req_strobe = 4'hF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_access.fv_before", {28'h0, a_fv}, 32'h2);
    rst_n = 1'b0;
    #1;
    check("rst_access.fv", {28'h0, a_fv}, 32'h0);
    check("rst_access.fwrite", {31'h0, a_fw}, 32'h0);
    check("rst_access.wdata", a_wdata, 32'h0);
    check("rst_access.mask", a_mask, 32'h0);
    check("rst_access.rdata", a_rdata, 32'h0);
    check("rst_access.status", {30'h0, a_status}, 32'h0);
    check("rst_access.rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_access.ready", {31'h0, a_req_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      check("rst_access.no_rsp", {30'h0, a_rsp_valid, b_rsp_valid}, 32'h0);
      @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      logic [7:0] addr;
      for (int k = 0; k < 4; k++) fields[k] = $urandom;
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      txn("rand", 1'($urandom), addr, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
